// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the upstream adder stage, the sum accumulator and
// its downstream consumer.
//   start     : begin a new accumulation (sampled in IDLE only)
//   in_sum    : 8-bit unsigned sum word from upstream
//   in_valid  : in_sum valid this cycle
//   in_ready  : accumulator accepts in_sum this cycle
//   acc       : 16-bit accumulated result
//   out_valid : acc holds a completed result
//   out_ready : downstream consumes the result
//   busy      : accumulator is in ACC or DONE
interface sum_accumulator_if;
  logic        start;
  logic [7:0]  in_sum;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] acc;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport master (
    output start, in_sum, in_valid, out_ready,
    input  in_ready, acc, out_valid, busy
  );

  modport slave (
    input  start, in_sum, in_valid, out_ready,
    output in_ready, acc, out_valid, busy
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned 8-bit sum words into a 16-bit result and presents
// it with a valid/ready handshake.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : sum_accumulator_if.slave (start, in_sum/in_valid/in_ready,
//         acc/out_valid/out_ready, busy)
module sum_accumulator #(
  parameter int unsigned COUNT = 4
) (
  input logic               clk,
  input logic               rst,
  sum_accumulator_if.slave  bus
);

  localparam int unsigned CW   = 8;
  localparam int unsigned AW   = 16;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [AW-1:0] acc;
  logic          in_ready;
  logic          out_valid;
  logic          busy;

  assign bus.acc       = acc;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;

  // State, datapath and registered handshake outputs; outputs are updated on
  // the same edge as the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ACC;
            count    <= '0;
            acc      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACC: begin
          if (bus.in_valid && in_ready) begin
            acc   <= acc + AW'(bus.in_sum);
            count <= count + CW'(1);
            // Final sample: result is visible right after this edge.
            if (count == LAST) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter COUNT, default 4, number of 8-bit sums accumulated per result; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-005 in_sum  input  8  sum word from the upstream 8-bit adder stage, unsigned.
REQ-006 in_valid  input  1  in_sum is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_sum this cycle.
REQ-008 acc  output  16  accumulated result, registered, unsigned.
REQ-009 out_valid  output  1  acc holds a completed result.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 busy  output  1  high in ACC or DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ACC, DONE.
REQ-013 IDLE: in_ready=0, out_valid=0, busy=0; start=1 -> ACC next cycle with acc cleared to 0 and sample counter cleared to 0.
REQ-014 ACC: in_ready=1, out_valid=0, busy=1; an input is accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-015 On accept: acc <= acc + zero-extended in_sum; counter <= counter+1; unaccepted cycles leave acc and counter unchanged.
REQ-016 When the accepted sample is number COUNT (counter == COUNT-1 at accept), the FSM SHALL enter DONE on the next edge.
REQ-017 DONE: in_ready=0, out_valid=1, busy=1, acc held stable until handshake.
REQ-018 DONE with out_ready=1 -> IDLE next cycle; out_valid deasserts that same edge; acc retains its final value in IDLE.
REQ-019 out_valid SHALL rise exactly one cycle after the clock edge accepting the final sample; no combinational path from in_valid or in_sum to out_valid or acc.
REQ-020 start SHALL be ignored in ACC and DONE; start and out_ready high together in DONE -> IDLE only; a new run needs start sampled in IDLE.
REQ-021 Width: 16-bit acc cannot overflow for COUNT<=255 (max 255*255=0xFE01); no carry-out or saturation logic.
REQ-022 COUNT=1: one accept in ACC -> DONE; acc equals that single in_sum.
REQ-023 out_ready in IDLE or ACC SHALL have no effect.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, acc=0x0000, counter=0, out_valid=0, in_ready=0, busy=0, independent of clk.
REQ-025 rst asserted mid-ACC or mid-DONE SHALL discard the partial or pending result; after deassertion the block waits in IDLE for start.
REQ-026 No input is accepted and no state changes on the first edge where rst is high.

Verification
REQ-027 COUNT=4, start, in_sum 08,30,FF,FF with in_valid continuous -> out_valid one cycle after 4th accept, acc=0x0236.
REQ-028 COUNT=4, in_valid low for 3 cycles between samples 2 and 3 -> identical acc=0x0236, in_ready held high throughout ACC.
REQ-029 Result ready, out_ready held low 5 cycles -> out_valid and acc=0x0236 stable all 5 cycles; out_ready=1 -> IDLE next cycle.
REQ-030 COUNT=255, 255 samples of FF -> acc=0xFE01, no wrap.
REQ-031 Reset asserted after 2 of 4 accepts -> acc=0x0000, IDLE, busy=0; fresh start with 01,02,03,04 -> acc=0x000A.
REQ-032 start pulsed during ACC and with out_ready in DONE -> ignored; returns to IDLE, stays there until next start.
